// File: rtl/am_demod_pkg.sv
// Shared types and default sizing for the sequenced AM magnitude engine.
package am_demod_pkg;

    localparam int WIDTH_DEF     = 12;
    localparam int CNT_WIDTH_DEF = 8;
    localparam int N             = 2 * WIDTH_DEF;
    localparam int REM_W         = WIDTH_DEF + 2;
    localparam int ITER_W        = $clog2(WIDTH_DEF);

    typedef enum logic [2:0] {
        S_IDLE,
        S_MUL_I,
        S_MUL_Q,
        S_SQRT,
        S_DONE
    } state_t;

endpackage

// File: rtl/am_isqrt_step.sv
// One restoring square-root iteration: consumes two radicand bits, yields one root bit.
module am_isqrt_step #(
    parameter int WIDTH = 12
) (
    input  logic [WIDTH+1:0] rem,
    input  logic [WIDTH-1:0] root,
    input  logic [1:0]       acc_top,
    output logic [WIDTH+1:0] rem_next,
    output logic [WIDTH-1:0] root_next
);

    localparam int RW = WIDTH + 2;

    // Two guard bits so the shifted remainder never wraps before the compare.
    logic [WIDTH+3:0] rem_shift;
    logic [WIDTH+3:0] trial;

    assign rem_shift = {rem, acc_top};
    assign trial     = {2'b00, root, 2'b01};

    always_comb begin
        rem_next  = RW'(rem_shift);
        root_next = {root[WIDTH-2:0], 1'b0};
        if (rem_shift >= trial) begin
            rem_next  = RW'(rem_shift - trial);
            root_next = {root[WIDTH-2:0], 1'b1};
        end
    end

endmodule

// File: rtl/am_demod_seq.sv
// Sequenced AM magnitude engine: floor(sqrt(I^2+Q^2)) using one shared squarer
// over two cycles followed by a bit-serial restoring square root.
module am_demod_seq
    import am_demod_pkg::*;
#(
    parameter int WIDTH     = WIDTH_DEF,
    parameter int CNT_WIDTH = CNT_WIDTH_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     I_in,
    input  logic [WIDTH-1:0]     Q_in,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     d_out,
    output logic                 busy,
    output logic [CNT_WIDTH-1:0] drop_cnt
);

    localparam int ACC_W = 2 * WIDTH;
    localparam int RW    = WIDTH + 2;
    localparam int IW    = $clog2(WIDTH);

    state_t state_reg, state_next;

    logic signed [WIDTH-1:0] i_reg, q_reg;
    logic [ACC_W-1:0]        acc_reg;
    logic [RW-1:0]           rem_reg;
    logic [WIDTH-1:0]        root_reg;
    logic [IW-1:0]           iter_reg;
    logic [WIDTH-1:0]        d_out_reg;
    logic                    out_valid_reg;
    logic [CNT_WIDTH-1:0]    drop_reg;

    logic signed [WIDTH-1:0] mul_op;
    logic signed [ACC_W-1:0] mul_prod;
    logic [ACC_W-1:0]        mul_sq;
    logic [RW-1:0]           rem_next;
    logic [WIDTH-1:0]        root_next;
    logic                    last_iter;
    logic                    dropping;

    // Single shared squarer: I in MUL_I, Q otherwise (only MUL_Q consumes it).
    assign mul_op    = (state_reg == S_MUL_I) ? i_reg : q_reg;
    assign mul_prod  = mul_op * mul_op;
    assign mul_sq    = $unsigned(mul_prod);
    assign last_iter = (iter_reg == IW'(WIDTH - 1));

    assign in_ready  = (state_reg == S_IDLE);
    assign busy      = (state_reg != S_IDLE);
    assign out_valid = out_valid_reg;
    assign d_out     = d_out_reg;
    assign drop_cnt  = drop_reg;
    assign dropping  = in_valid && !in_ready;

    am_isqrt_step #(
        .WIDTH(WIDTH)
    ) u_step (
        .rem      (rem_reg),
        .root     (root_reg),
        .acc_top  (acc_reg[ACC_W-1:ACC_W-2]),
        .rem_next (rem_next),
        .root_next(root_next)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE:  if (in_valid) state_next = S_MUL_I;
            S_MUL_I: state_next = S_MUL_Q;
            S_MUL_Q: state_next = S_SQRT;
            S_SQRT:  if (last_iter) state_next = S_DONE;
            S_DONE:  if (out_ready) state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            i_reg         <= '0;
            q_reg         <= '0;
            acc_reg       <= '0;
            rem_reg       <= '0;
            root_reg      <= '0;
            iter_reg      <= '0;
            d_out_reg     <= '0;
            out_valid_reg <= 1'b0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (in_valid) begin
                        i_reg <= I_in;
                        q_reg <= Q_in;
                    end
                end
                S_MUL_I: begin
                    acc_reg <= mul_sq;
                end
                S_MUL_Q: begin
                    acc_reg  <= acc_reg + mul_sq;
                    rem_reg  <= '0;
                    root_reg <= '0;
                    iter_reg <= '0;
                end
                S_SQRT: begin
                    rem_reg  <= rem_next;
                    root_reg <= root_next;
                    acc_reg  <= acc_reg << 2;
                    iter_reg <= iter_reg + IW'(1);
                    if (last_iter) begin
                        d_out_reg     <= root_next;
                        out_valid_reg <= 1'b1;
                    end
                end
                S_DONE: begin
                    if (out_ready) out_valid_reg <= 1'b0;
                end
                default: begin
                    out_valid_reg <= 1'b0;
                end
            endcase
        end
    end

    // Saturating count of offered-but-refused cycles; only reset clears it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_reg <= '0;
        end else if (dropping && (drop_reg != '1)) begin
            drop_reg <= drop_reg + CNT_WIDTH'(1);
        end
    end

endmodule

// File: tb/tb_am_demod_seq.sv
// Randomised and directed bench for am_demod_seq against a countdown-based magnitude model.
module tb_am_demod_seq;

    localparam int W   = 12;
    localparam int LAT = W + 2;

    logic                clk = 1'b0;
    logic                rst_n;
    logic                in_valid;
    logic                in_ready;
    logic signed [W-1:0] I_in;
    logic signed [W-1:0] Q_in;
    logic                out_valid;
    logic                out_ready;
    logic [W-1:0]        d_out;
    logic                busy;
    logic [7:0]          drop_cnt;

    am_demod_seq #(.WIDTH(W), .CNT_WIDTH(8)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .I_in     (I_in),
        .Q_in     (Q_in),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .d_out    (d_out),
        .busy     (busy),
        .drop_cnt (drop_cnt)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d at t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic int isqrt_ref(input int i, input int q);
        longint s;
        longint r;
        s = longint'(i) * i + longint'(q) * q;
        r = 0;
        while ((r + 1) * (r + 1) <= s) r++;
        return int'(r);
    endfunction

    // Model: idle / counting down to result / holding result.
    bit  m_idle = 1'b1;
    int  m_cnt  = 0;
    bit  m_done = 1'b0;
    int  m_res  = 0;
    int  m_dout = 0;
    int  m_drop = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_idle = 1'b1; m_cnt = 0; m_done = 1'b0;
            m_res = 0; m_dout = 0; m_drop = 0;
        end else begin
            if (in_valid && !m_idle && m_drop < 255) m_drop++;
            if (m_idle) begin
                if (in_valid) begin
                    m_res  = isqrt_ref(int'(I_in), int'(Q_in));
                    m_cnt  = LAT;
                    m_idle = 1'b0;
                end
            end else if (m_cnt > 0) begin
                m_cnt--;
                if (m_cnt == 0) begin
                    m_done = 1'b1;
                    m_dout = m_res;
                end
            end else if (m_done && out_ready) begin
                m_done = 1'b0;
                m_idle = 1'b1;
            end
        end
    end

    bit cmp_en = 1'b0;
    always @(negedge clk) begin
        if (cmp_en) begin
            chk("in_ready", in_ready, m_idle);
            chk("busy", busy, !m_idle);
            chk("out_valid", out_valid, m_done);
            chk("d_out", d_out, m_dout);
            chk("drop_cnt", drop_cnt, m_drop);
        end
    end

    // Accept-period monitor for the streaming run.
    bit     stream_en    = 1'b0;
    longint cyc          = 0;
    longint last_acc_cyc = -1;
    int     stream_acc   = 0;
    always @(posedge clk) begin
        cyc++;
        if (rst_n && in_valid && in_ready && stream_en) begin
            if (last_acc_cyc >= 0) chk("accept_period", cyc - last_acc_cyc, W + 4);
            last_acc_cyc = cyc;
            stream_acc++;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (!in_ready && n < 200) begin
            step();
            n++;
        end
        if (!in_ready) chk("idle_timeout", 0, 1);
    endtask

    task automatic send(input int i, input int q, input int exp_val);
        int n;
        wait_idle();
        chk("model_pin", isqrt_ref(i, q), exp_val);
        in_valid = 1'b1;
        I_in = W'(i);
        Q_in = W'(q);
        step();
        in_valid = 1'b0;
        I_in = W'($urandom);
        Q_in = W'($urandom);
        n = 0;
        while (!out_valid && n < 100) begin
            step();
            n++;
        end
        chk("latency", n, LAT);
        chk("result", d_out, exp_val);
        step();
        chk("out_valid_pulse", out_valid, 0);
        $display("sample I=%0d Q=%0d d_out=%0d expected=%0d latency=%0d", i, q, d_out, exp_val, n);
    endtask

    int ti[5] = '{0, 2047, -2048, 100, -2048};
    int tq[5] = '{0, 0, 0, -100, -2048};
    int te[5] = '{0, 2047, 2048, 141, 2896};

    initial begin
        int d0;
        int n;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        I_in      = '0;
        Q_in      = '0;
        repeat (3) step();
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_d_out", d_out, 0);
        chk("rst_busy", busy, 0);
        chk("rst_drop", drop_cnt, 0);
        rst_n = 1'b1;
        cmp_en = 1'b1;
        step();

        send(3, 4, 5);
        for (int k = 0; k < 5; k++) send(ti[k], tq[k], te[k]);

        // Backpressure with in_valid held high while the result waits.
        wait_idle();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        I_in = 3; Q_in = 4;
        step();
        I_in = W'($urandom); Q_in = W'($urandom);
        n = 0;
        while (!out_valid && n < 100) begin step(); n++; end
        d0 = drop_cnt;
        repeat (20) step();
        chk("bp_out_valid", out_valid, 1);
        chk("bp_d_out", d_out, 5);
        chk("bp_in_ready", in_ready, 0);
        chk("bp_drop", drop_cnt, d0 + 20);
        $display("backpressure d_out=%0d drop_cnt=%0d start=%0d", d_out, drop_cnt, d0);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        chk("bp_release", out_valid, 0);
        chk("bp_hold_dout", d_out, 5);

        // Drop counter saturation.
        wait_idle();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        repeat (300) step();
        chk("drop_sat", drop_cnt, 255);
        repeat (10) step();
        chk("drop_sat_hold", drop_cnt, 255);
        $display("saturation drop_cnt=%0d", drop_cnt);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();

        // Reset in the middle of the square root.
        wait_idle();
        in_valid = 1'b1;
        I_in = 100; Q_in = 200;
        step();
        in_valid = 1'b0;
        repeat (5) step();
        chk("pre_reset_busy", busy, 1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_in_ready", in_ready, 1);
        chk("mid_rst_out_valid", out_valid, 0);
        chk("mid_rst_d_out", d_out, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_drop", drop_cnt, 0);
        $display("mid-sqrt reset busy=%0d out_valid=%0d", busy, out_valid);
        step();
        rst_n = 1'b1;
        step();
        chk("post_rst_out_valid", out_valid, 0);
        send(5, 12, 13);

        // Back-to-back random stream.
        wait_idle();
        last_acc_cyc = -1;
        stream_acc   = 0;
        stream_en    = 1'b1;
        in_valid     = 1'b1;
        n = 0;
        while (stream_acc < 1000 && n < 1000 * (W + 4) + 100) begin
            I_in = W'($urandom);
            Q_in = W'($urandom);
            step();
            n++;
        end
        in_valid = 1'b0;
        repeat (LAT + 4) step();
        stream_en = 1'b0;
        chk("stream_accepts", stream_acc, 1000);
        $display("stream accepted=%0d cycles=%0d", stream_acc, n);

        cmp_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1_000_000;
        failures++;
        $display("FAIL global_timeout actual=running expected=finished");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
